// File: rtl/uart_transmitter.sv
// UART serialiser: 8N1 frames, LSB first (8E1 when UART_TX_PARITY_EN is defined), one-byte holding register.
// Start bit begins one clock after the handshake; ready_o stays low while the holding register is full.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       TXD_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int            CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          LP_STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic          r_stop_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic          r_txd;
    logic          r_busy;
    logic          r_done;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic w_bit_end;
    logic w_frame_end;
    logic w_load;
    logic w_hs;

    assign w_bit_end   = (r_bit_cnt == LP_BIT_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == LP_STOP_LAST);
    // The held byte moves into the shifter from IDLE, or straight off the last stop bit so frames abut.
    assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_frame_end);
    // A full holding register never accepts, so a write and a transfer cannot share an edge.
    assign w_hs        = valid_i && !r_hold_full;

    assign ready_o = !r_hold_full;
    assign TXD_o   = r_txd;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else if (w_hs) begin
            r_hold      <= data_i;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= '0;
        end else if (w_load || r_state == S_IDLE || w_bit_end) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bit_idx  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= w_frame_end;
            if (w_load) begin
                r_state    <= S_START;
                r_shift    <= r_hold;
                r_bit_idx  <= 3'd0;
                r_stop_cnt <= 1'b0;
                r_txd      <= 1'b0;
                r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parity   <= ^r_hold;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_txd  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                            r_txd     <= r_shift[0];
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                r_state    <= S_PARITY;
                                r_txd      <= r_parity;
`else
                                r_state    <= S_STOP;
                                r_stop_cnt <= 1'b0;
                                r_txd      <= 1'b1;
`endif
                            end else begin
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_txd     <= r_shift[1];
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= S_STOP;
                            r_stop_cnt <= 1'b0;
                            r_txd      <= 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_frame_end) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_txd   <= 1'b1;
                        end else if (w_bit_end) begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-timeline model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;
    localparam int LIMIT = 4 * FRAME;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       ready_o, TXD_o, busy_o, done_o;

    int n_cmp     = 0;
    int n_err     = 0;
    int done_seen = 0;
    bit chk_en    = 1'b0;

    uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .TXD_o   (TXD_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: a frame is a start time plus a byte; the line level follows from elapsed time.
    int         m_n         = 0;
    int         m_start     = 0;
    bit         m_active    = 1'b0;
    bit         m_done      = 1'b0;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] m_byte      = 8'h00;

    function automatic logic exp_bit(input logic [7:0] b, input int t);
        int         k;
        logic [7:0] s;
        k = t / C;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            s = b >> (k - 1);
            return s[0];
        end
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        bit hf;
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_active    = 1'b0;
            m_done      = 1'b0;
            m_hold_full = 1'b0;
        end else begin
            hf     = m_hold_full;
            m_n    = m_n + 1;
            m_done = 1'b0;
            if (m_active && (m_n - m_start) == FRAME) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end
            if (!m_active && hf) begin
                m_active    = 1'b1;
                m_start     = m_n;
                m_byte      = m_hold;
                m_hold_full = 1'b0;
            end
            if (valid_i && !hf) begin
                m_hold      = data_i;
                m_hold_full = 1'b1;
            end
        end
    end

    initial forever begin
        logic [3:0] ex;
        logic [3:0] ac;
        @(negedge clk_i);
        if (chk_en) begin
            ex[3] = m_active ? exp_bit(m_byte, m_n - m_start) : 1'b1;
            ex[2] = m_active;
            ex[1] = m_done;
            ex[0] = !m_hold_full;
            ac    = {TXD_o, busy_o, done_o, ready_o};
            n_cmp = n_cmp + 1;
            if (ac !== ex) begin
                n_err = n_err + 1;
                $display("FAIL model t=%0t txd/busy/done/ready got %b want %b", $time, ac, ex);
            end
            if (done_o === 1'b1) done_seen = done_seen + 1;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_txd"},   TXD_o,   1'b1);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_busy"},  busy_o,  1'b0);
        check({tag, "_done"},  done_o,  1'b0);
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic [7:0] b);
        int w;
        valid_i = 1'b1;
        data_i  = b;
        w       = 0;
        while (ready_o !== 1'b1 && w < LIMIT) begin
            step(1);
            w = w + 1;
        end
        if (w >= LIMIT) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL send_timeout: ready_o stayed %b for %0d cycles", ready_o, w);
        end
        step(1);
        valid_i = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int         d0;

        // Asynchronous reset, asserted and released between clock edges.
        #2 rst_i = 1'b1;
        chk_en = 1'b1;
        #1 check_reset_vals("rst_assert");
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1 check_reset_vals("rst_release");
        step(1);

        // 0x55 from idle.
        send(8'h55);
        step(1);
        check("s55_start_txd", TXD_o, 1'b0);
        check("s55_start_busy", busy_o, 1'b1);
        check("s55_start_ready", ready_o, 1'b1);
        step(8);
        check("s55_start_mid", TXD_o, 1'b0);
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            step(16);
            check("s55_data_bit", TXD_o, pat[i]);
        end
        step(FRAME - 8 - 136);
        check("s55_stop", TXD_o, 1'b1);
        step(7);
        check("s55_done_early", done_o, 1'b0);
        check("s55_busy_late", busy_o, 1'b1);
        step(1);
        check("s55_done", done_o, 1'b1);
        check("s55_busy_drop", busy_o, 1'b0);
        check("s55_idle_txd", TXD_o, 1'b1);
        step(1);
        check("s55_done_once", done_o, 1'b0);
        step(3);

        // 0xA3 then 0x0F offered 20 cycles later; frames must abut.
        send(8'hA3);
        step(20);
        check("b2b_ready_free", ready_o, 1'b1);
        send(8'h0F);
        check("b2b_ready_held", ready_o, 1'b0);
        step(FRAME - 21);
        check("b2b_ready_still", ready_o, 1'b0);
        check("b2b_stop_txd", TXD_o, 1'b1);
        step(1);
        check("b2b_done_a3", done_o, 1'b1);
        check("b2b_start_0f", TXD_o, 1'b0);
        check("b2b_busy_kept", busy_o, 1'b1);
        check("b2b_ready_back", ready_o, 1'b1);
        step(FRAME);
        check("b2b_done_0f", done_o, 1'b1);
        check("b2b_busy_drop", busy_o, 1'b0);
        step(3);

        // valid_i held with changing data_i while the holding register is full.
        send(8'h3C);
        send(8'hC6);
        valid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_i = 8'(i * 37 + 5);
            check("hold_blocked_ready", ready_o, 1'b0);
            step(1);
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
        step(FRAME - 41);
        check("hold_done_3c", done_o, 1'b1);
        check("hold_start_c6", TXD_o, 1'b0);
        step(24);
        check("hold_c6_bit0", TXD_o, 1'b0);
        step(16);
        check("hold_c6_bit1", TXD_o, 1'b1);
        step(FRAME - 40);
        check("hold_done_c6", done_o, 1'b1);
        step(3);

        // Reset during data bit 4 of 0xFF, then a clean 0x81 frame.
        send(8'hFF);
        step(1);
        step(85);
        check("rst_mid_bit4", TXD_o, 1'b1);
        check("rst_mid_busy", busy_o, 1'b1);
        d0 = done_seen;
        #2 rst_i = 1'b1;
        #1 check_reset_vals("rst_mid");
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        step(1);
        check_int("rst_mid_no_done", done_seen, d0);
        send(8'h81);
        step(1);
        check("s81_start", TXD_o, 1'b0);
        step(8 + 16);
        check("s81_bit0", TXD_o, 1'b1);
        step(16);
        check("s81_bit1", TXD_o, 1'b0);
        step(FRAME - 1 - 40);
        check("s81_done_early", done_o, 1'b0);
        step(1);
        check("s81_done", done_o, 1'b1);
        step(3);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        step(1);
        step(8 + 16 * 9);
        check("par07_bit", TXD_o, 1'b1);
        step(175 - 152);
        check("par07_done_early", done_o, 1'b0);
        step(1);
        check("par07_done_176", done_o, 1'b1);
        step(3);
        send(8'h03);
        step(1);
        step(8 + 16 * 9);
        check("par03_bit", TXD_o, 1'b0);
        step(176 - 152);
        check("par03_done_176", done_o, 1'b1);
        step(3);
        check_int("total_done", done_seen, 8);
`else
        check_int("total_done", done_seen, 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmit engine: serialises 8-bit bytes onto `TXD_o` as 8N1 frames (optionally 8E1), LSB first, at a fixed bit period of `CLKS_PER_BIT` clocks. It is the transmit counterpart of the design's 9600-baud receiver and shares its bit timing (100 MHz / 9600 ≈ 10416 clocks). A one-byte holding register behind a valid/ready handshake lets the producer queue the next byte during a frame, so back-to-back frames have no idle gap.

## Interface
- `CLKS_PER_BIT`, default 10416: clocks per bit; legal values are ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.

Ports:
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `data_i`  in  8  byte to send; sampled only on handshake.
- `valid_i`  in  1  producer has a byte on `data_i`.
- `ready_o`  out  1  holding register empty; handshake = `valid_i & ready_o` at rising edge.
- `TXD_o`  out  1  serial line, idle high, registered.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values (all asynchronous):
  - `TXD_o` = 1, `ready_o` = 1, `busy_o` = 0, `done_o` = 0.
  - Holding register empty; FSM in IDLE; all counters 0.
- Holding register (`hold`, `hold_full`):
  - A handshake writes `data_i` into `hold` and sets `hold_full`.
  - `ready_o` = !`hold_full`, registered.
- FSM states:
  - IDLE: `TXD_o` = 1. If `hold_full`, load the shift register from `hold`, clear `hold_full`, and go to START.
  - START: `TXD_o` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `TXD_o` = shift[0]. Shift right every `CLKS_PER_BIT` cycles. After 8 bits, go to PARITY (macro enabled) or STOP.
  - PARITY: `TXD_o` = XOR of the 8 data bits (even parity) for one bit period, then go to STOP.
  - STOP: `TXD_o` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles. At the end, pulse `done_o`.
    - If `hold_full`: load the shift register, clear `hold_full`, and go straight to START.
    - Otherwise: go to IDLE.
- Counters:
  - Bit-period counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - Bit index: 3 bits. Stop counter: 1 bit.
- Boundary conditions:
  - Handshake on the same edge that `hold` is transferred out: legal only if `ready_o` was already high. There is no simultaneous write and read of a full hold.
  - `valid_i` high while `ready_o` = 0: no effect, and `data_i` is ignored.
  - Reset mid-frame: `TXD_o` goes to 1 immediately. The frame and the held byte are discarded. There is no `done_o` pulse.
  - `data_i` changes after the handshake do not affect the frame in flight.

## Timing
- Handshake at edge k: `hold_full` = 1 and `ready_o` = 0 after edge k.
- From IDLE:
  - Edge k+1: FSM enters START, `TXD_o` falls, `hold` is transferred, and `ready_o` returns to 1.
  - Latency from handshake to start bit is 1 cycle.
- Frame length from the start-bit edge: (1 + 8 + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P = 1 with parity, 0 without.
  - `done_o` is high for the single cycle following the last stop-bit clock.
  - The next start bit (if `hold_full`) begins on that same edge.
- `busy_o` rises with the start bit. It falls on the edge that enters IDLE.
- Sustained throughput: one frame every frame-length cycles, with no gap.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and an even parity bit is inserted after D7; frame = 11 bits (1 stop).
  - Undefined: the PARITY state and parity logic are absent; frame = 10 bits, 8N1.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16, `STOP_BITS` = 1, macro undefined unless stated.
- Assert then release `rst_i` asynchronously mid-cycle -> `TXD_o` = 1, `ready_o` = 1, `busy_o` = 0, `done_o` = 0 immediately.
- Send 0x55 from idle -> `TXD_o` low 16 cycles starting 1 cycle after the handshake, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high 16 cycles. `done_o` pulses once, 160 cycles after the start-bit edge, and `busy_o` then drops.
- Send 0xA3, then 0x0F offered 20 cycles later -> 0x0F is accepted while 0xA3 is in DATA. `ready_o` stays 0 until the second start bit. The 0x0F start bit begins on the same edge as the 0xA3 `done_o`, with zero idle cycles.
- Hold `valid_i` = 1 with changing `data_i` while `ready_o` = 0 -> no extra handshake. Only the byte present at the accepting edge is transmitted.
- Assert `rst_i` during DATA bit 4 of 0xFF -> `TXD_o` = 1 at once and no `done_o`. After release, 0x81 is sent with a correct 160-cycle frame.
- With `UART_TX_PARITY_EN` defined -> 0x07 gives parity bit 1, 0x03 gives parity bit 0. The frame is 176 cycles and `done_o` pulses at cycle 176.
